binary_perceptron: RTL and testbench

Single-neuron, two-input binary perceptron with on-chip training. It predicts y = step(w1·x1 + w2·x2 + b) for 1-bit inputs. It trains its weights with the perceptron rule against a 4-entry truth table. It sits behind the AXI perceptron slave, which drives its control/config ports and reads back weights and status.

---
 rtl/binary_perceptron.sv | 155 +++++++++++++++
 tb/tb_binary_perceptron.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/binary_perceptron.sv
// Two-input binary perceptron with on-chip perceptron-rule training over a 4-entry truth table.
// Define BINARY_PERCEPTRON_SAT_EN to saturate weight/bias updates; otherwise they wrap modulo 2^W.
module binary_perceptron #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                x1,
  input  logic                x2,
  output logic                y,
  output logic signed [W+1:0] sum_dbg,
  input  logic                train_start,
  input  logic [3:0]          targets,
  input  logic [15:0]         max_epochs,
  input  logic signed [W-1:0] eta,
  input  logic                load_init,
  input  logic signed [W-1:0] w1_init,
  input  logic signed [W-1:0] w2_init,
  input  logic signed [W-1:0] b_init,
  output logic signed [W-1:0] w1_o,
  output logic signed [W-1:0] w2_o,
  output logic signed [W-1:0] b_o,
  output logic                converged
);

  typedef enum logic [1:0] {IDLE, TRAIN, DONE} state_t;

  localparam logic signed [W+1:0] ZERO  = '0;
  localparam logic signed [W+1:0] W_MAX = (W+2)'((2 ** (W - 1)) - 1);
  localparam logic signed [W+1:0] W_MIN = -W_MAX - 1;

  state_t              state;
  logic signed [W-1:0] w1, w2, b, eta_q;
  logic [3:0]          tgt_q;
  logic [15:0]         max_q;
  logic [15:0]         epoch_count;
  logic [1:0]          idx;
  logic                err;
  logic                done;

  logic signed [W+1:0] train_sum;
  logic signed [W+1:0] eta_ext;
  logic signed [W+1:0] delta;
  logic                tgt;
  logic                miss;

  function automatic logic signed [W+1:0] weighted_sum(
    input logic signed [W-1:0] a1,
    input logic signed [W-1:0] a2,
    input logic signed [W-1:0] ab,
    input logic                i1,
    input logic                i2
  );
    logic signed [W+1:0] s;
    s = {{2{ab[W-1]}}, ab};
    if (i1) s = s + {{2{a1[W-1]}}, a1};
    if (i2) s = s + {{2{a2[W-1]}}, a2};
    return s;
  endfunction

  function automatic logic signed [W-1:0] apply_delta(
    input logic signed [W-1:0] v,
    input logic signed [W+1:0] d
  );
    logic signed [W+1:0] r;
    r = {{2{v[W-1]}}, v} + d;
`ifdef BINARY_PERCEPTRON_SAT_EN
    if (r > W_MAX) r = W_MAX;
    else if (r < W_MIN) r = W_MIN;
`endif
    return $signed(r[W-1:0]);
  endfunction

  // Training walks samples 00,01,10,11, so idx doubles as {x1,x2}.
  assign sum_dbg   = weighted_sum(w1, w2, b, x1, x2);
  assign train_sum = weighted_sum(w1, w2, b, idx[1], idx[0]);
  assign tgt       = tgt_q[idx];
  assign miss      = (train_sum > ZERO) != tgt;
  assign eta_ext   = {{2{eta_q[W-1]}}, eta_q};
  assign delta     = tgt ? eta_ext : -eta_ext;

  assign w1_o = w1;
  assign w2_o = w2;
  assign b_o  = b;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state       <= IDLE;
      w1          <= '0;
      w2          <= '0;
      b           <= '0;
      eta_q       <= '0;
      tgt_q       <= '0;
      max_q       <= '0;
      epoch_count <= '0;
      idx         <= '0;
      err         <= 1'b0;
      done        <= 1'b0;
      converged   <= 1'b0;
      y           <= 1'b0;
    end else begin
      y <= (sum_dbg > ZERO);
      case (state)
        IDLE, DONE: begin
          // load_init wins over a simultaneous train_start
          if (load_init) begin
            w1 <= w1_init;
            w2 <= w2_init;
            b  <= b_init;
          end else if (train_start) begin
            tgt_q       <= targets;
            eta_q       <= eta;
            max_q       <= max_epochs;
            converged   <= 1'b0;
            epoch_count <= '0;
            idx         <= '0;
            err         <= 1'b0;
            if (max_epochs == 16'd0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              done  <= 1'b0;
              state <= TRAIN;
            end
          end
        end
        TRAIN: begin
          if (miss) begin
            b <= apply_delta(b, delta);
            if (idx[1]) w1 <= apply_delta(w1, delta);
            if (idx[0]) w2 <= apply_delta(w2, delta);
          end
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            epoch_count <= epoch_count + 16'd1;
            err         <= 1'b0;
            if (!(err || miss)) begin
              converged <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else if (({1'b0, epoch_count} + 17'd1) >= {1'b0, max_q}) begin
              converged <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
          end else begin
            err <= err | miss;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_perceptron.sv
// Self-checking bench for binary_perceptron: truth-table training runs, control guards, reset abort and
// saturation/wrap behaviour (follows BINARY_PERCEPTRON_SAT_EN).
module tb_binary_perceptron;

  localparam int W = 8;

  logic                clk = 1'b0;
  logic                aresetn;
  logic                x1, x2;
  logic                y;
  logic signed [W+1:0] sum_dbg;
  logic                train_start;
  logic [3:0]          targets;
  logic [15:0]         max_epochs;
  logic signed [W-1:0] eta;
  logic                load_init;
  logic signed [W-1:0] w1_init, w2_init, b_init;
  logic signed [W-1:0] w1_o, w2_o, b_o;
  logic                converged;

  int   compared   = 0;
  int   mismatched = 0;
  logic exp_q[$];

  binary_perceptron #(.W(W)) dut (
    .clk(clk), .aresetn(aresetn), .x1(x1), .x2(x2), .y(y), .sum_dbg(sum_dbg),
    .train_start(train_start), .targets(targets), .max_epochs(max_epochs), .eta(eta),
    .load_init(load_init), .w1_init(w1_init), .w2_init(w2_init), .b_init(b_init),
    .w1_o(w1_o), .w2_o(w2_o), .b_o(b_o), .converged(converged)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] tgt;
    int         eta_v;
    int         max_ep;
    logic       exp_conv;
    int         exp_ep;
    int         exp_w1;
    int         exp_w2;
    int         exp_b;
  } vec_t;

  vec_t  vecs[5];
  string names[5];

  function automatic int limit(input int v);
`ifdef BINARY_PERCEPTRON_SAT_EN
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
`else
    return ((v & 255) >= 128) ? (v & 255) - 256 : (v & 255);
`endif
  endfunction

  // Straight-line reference of the perceptron rule, one epoch at a time.
  function automatic void model(input logic [3:0] tg, input int et, input int maxe,
                                input int w1i, input int w2i, input int bi,
                                output logic conv, output int ep,
                                output int w1, output int w2, output int b);
    conv = 1'b0; ep = 0; w1 = w1i; w2 = w2i; b = bi;
    for (int e = 0; e < maxe; e++) begin
      bit errf;
      errf = 1'b0;
      for (int k = 0; k < 4; k++) begin
        int a, c, d;
        a = k / 2; c = k % 2;
        if (((w1 * a + w2 * c + b) > 0) != tg[k]) begin
          errf = 1'b1;
          d = tg[k] ? et : -et;
          b = limit(b + d);
          if (a == 1) w1 = limit(w1 + d);
          if (c == 1) w2 = limit(w2 + d);
        end
      end
      ep++;
      if (!errf) begin
        conv = 1'b1;
        return;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic a, input logic c, input logic exp_y);
    x1 = a;
    x2 = c;
    exp_q.push_back(exp_y);
  endtask

  task automatic check_prediction(input string name);
    tick();
    if (exp_q.size() == 0) checkOutput({name, "_sb_empty"}, 0, 1);
    else checkOutput(name, int'(y), int'(exp_q.pop_front()));
  endtask

  task automatic load_weights(input int a, input int c, input int bb);
    w1_init = a[W-1:0]; w2_init = c[W-1:0]; b_init = bb[W-1:0];
    load_init = 1'b1;
    tick();
    load_init = 1'b0;
  endtask

  task automatic start_train(input logic [3:0] tg, input int et, input int maxe);
    targets = tg; eta = et[W-1:0]; max_epochs = maxe[15:0];
    train_start = 1'b1;
    tick();
    train_start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int cycles);
    cycles = 0;
    while (!dut.done && cycles < bound) begin
      tick();
      cycles++;
    end
    if (!dut.done) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic check_run(input string name, input logic ec, input int eep,
                           input int ew1, input int ew2, input int eb);
    checkOutput({name, "_done"}, int'(dut.done), 1);
    checkOutput({name, "_converged"}, int'(converged), int'(ec));
    checkOutput({name, "_epochs"}, int'(dut.epoch_count), eep);
    checkOutput({name, "_w1"}, int'(w1_o), ew1);
    checkOutput({name, "_w2"}, int'(w2_o), ew2);
    checkOutput({name, "_b"}, int'(b_o), eb);
  endtask

  initial begin
    int cycles, nmiss, s;
    logic mc; int me, m1, m2, mb;

    aresetn = 1'b0; x1 = 0; x2 = 0; train_start = 0; load_init = 0;
    targets = '0; max_epochs = '0; eta = '0; w1_init = '0; w2_init = '0; b_init = '0;

    names[0] = "and";  vecs[0] = '{4'b1000, 16, 16, 1'b1, 6, 32, 16, -32};
    names[1] = "or";   vecs[1] = '{4'b1110, 16, 16, 1'b1, 0, 0, 0, 0};
    names[2] = "nand"; vecs[2] = '{4'b0111, 16, 16, 1'b1, 0, 0, 0, 0};
    names[3] = "nor";  vecs[3] = '{4'b0001, 16, 16, 1'b1, 0, 0, 0, 0};
    names[4] = "xor";  vecs[4] = '{4'b0110, 16, 16, 1'b0, 16, 0, 0, 0};
    for (int i = 1; i < 5; i++) begin
      model(vecs[i].tgt, vecs[i].eta_v, vecs[i].max_ep, 0, 0, 0, mc, me, m1, m2, mb);
      if (i != 4) vecs[i].exp_ep = me;
      vecs[i].exp_w1 = m1; vecs[i].exp_w2 = m2; vecs[i].exp_b = mb;
    end

    tick(); tick();
    checkOutput("rst_y", int'(y), 0);
    checkOutput("rst_converged", int'(converged), 0);
    checkOutput("rst_done", int'(dut.done), 0);
    checkOutput("rst_epochs", int'(dut.epoch_count), 0);
    checkOutput("rst_w1", int'(w1_o), 0);
    checkOutput("rst_w2", int'(w2_o), 0);
    checkOutput("rst_b", int'(b_o), 0);
    aresetn = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      load_weights(0, 0, 0);
      start_train(vecs[i].tgt, vecs[i].eta_v, vecs[i].max_ep);
      wait_done(4 * vecs[i].max_ep + 8, cycles);
      check_run(names[i], vecs[i].exp_conv, vecs[i].exp_ep,
                vecs[i].exp_w1, vecs[i].exp_w2, vecs[i].exp_b);
      checkOutput({names[i], "_cycles"}, cycles, 4 * vecs[i].exp_ep);
      nmiss = 0;
      for (int k = 0; k < 4; k++) begin
        s = vecs[i].exp_w1 * (k / 2) + vecs[i].exp_w2 * (k % 2) + vecs[i].exp_b;
        applyStimulus(k / 2, k % 2, vecs[i].exp_conv ? vecs[i].tgt[k] : (s > 0));
        check_prediction({names[i], "_y"});
        if (y != vecs[i].tgt[k]) nmiss++;
      end
      if (i == 4) checkOutput("xor_mispredicts", int'(nmiss > 0), 1);
      x1 = 0; x2 = 0;
    end

    // AND weights (32,16,-32) at input 11 give a sum of 16.
    load_weights(32, 16, -32);
    x1 = 1; x2 = 1;
    #1;
    checkOutput("sum_dbg_11", int'(sum_dbg), 16);
    x1 = 0; x2 = 0;

    // Control inputs pulsed mid-run must not disturb an AND training run.
    load_weights(0, 0, 0);
    start_train(4'b1000, 16, 16);
    for (int k = 0; k < 5; k++) tick();
    w1_init = 50; w2_init = 50; b_init = 50; targets = 4'b0110;
    load_init = 1'b1; train_start = 1'b1;
    tick();
    load_init = 1'b0; train_start = 1'b0;
    wait_done(64, cycles);
    check_run("guard", 1'b1, 6, 32, 16, -32);
    checkOutput("guard_cycles", cycles + 6, 24);

    // Both high while DONE: load applies, start ignored.
    w1_init = 10; w2_init = 20; b_init = -30;
    load_init = 1'b1; train_start = 1'b1; max_epochs = 16'd5;
    tick();
    load_init = 1'b0; train_start = 1'b0;
    checkOutput("both_w1", int'(w1_o), 10);
    checkOutput("both_b", int'(b_o), -30);
    checkOutput("both_done_kept", int'(dut.done), 1);
    checkOutput("both_epochs_kept", int'(dut.epoch_count), 6);

    start_train(4'b1000, 16, 0);
    checkOutput("max0_done", int'(dut.done), 1);
    checkOutput("max0_converged", int'(converged), 0);
    checkOutput("max0_epochs", int'(dut.epoch_count), 0);
    checkOutput("max0_w2", int'(w2_o), 20);

    load_weights(120, 120, 120);
    start_train(4'b0000, 127, 16);
    tick();
    checkOutput("sat_s00_b", int'(b_o), -7);
    tick();
    checkOutput("sat_s01_w2", int'(w2_o), -7);
`ifdef BINARY_PERCEPTRON_SAT_EN
    checkOutput("sat_s01_b", int'(b_o), -128);
    for (int k = 0; k < 6 && !dut.done; k++) begin
      tick();
      checkOutput("sat_b_hold", int'(b_o), -128);
    end
`else
    checkOutput("wrap_s01_b", int'(b_o), 122);
`endif
    wait_done(64, cycles);
    model(4'b0000, 127, 16, 120, 120, 120, mc, me, m1, m2, mb);
    check_run("sat_final", mc, me, m1, m2, mb);

    // Reset mid-run aborts everything on the reset edge.
    load_weights(16, 16, 16);
    x1 = 1; x2 = 1;
    start_train(4'b0110, 16, 16);
    for (int k = 0; k < 6; k++) tick();
    aresetn = 1'b0;
    tick();
    checkOutput("abort_y", int'(y), 0);
    checkOutput("abort_w1", int'(w1_o), 0);
    checkOutput("abort_w2", int'(w2_o), 0);
    checkOutput("abort_b", int'(b_o), 0);
    checkOutput("abort_done", int'(dut.done), 0);
    checkOutput("abort_epochs", int'(dut.epoch_count), 0);
    checkOutput("abort_converged", int'(converged), 0);
    aresetn = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
